// File: rtl/m_stage_lsu.sv
// Memory stage: forwards ALU results to write-back and serializes vector loads/stores into
// BEAT_W-bit req/ack beats, stalling the upstream pipeline while an access is in flight.
module m_stage_lsu #(
    parameter int REGI_SIZE  = 16,
    parameter int ELEM_SIZE  = 8,
    parameter int VECT_SIZE  = 8,
    parameter int MEMO_LINES = 64,
    parameter int BEAT_W     = 16,
    parameter int REGI_BITS  = 4,
    localparam int VW        = ELEM_SIZE * VECT_SIZE,
    localparam int BEATS     = VW / BEAT_W,
    localparam int LINE_W    = $clog2(MEMO_LINES),
    localparam int BEAT_BITS = $clog2(BEATS),
    localparam int AW        = LINE_W + BEAT_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    input  logic [REGI_SIZE-1:0] ialu_res_i,
    input  logic [VW-1:0]        valu_res_i,
    input  logic [VW-1:0]        mem_data_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [REGI_BITS-1:0] dst_i,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [BEAT_W-1:0]    mem_wdata_o,
    input  logic [BEAT_W-1:0]    mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic                 wb_valid_o,
    output logic                 wb_wen_o,
    output logic [REGI_SIZE-1:0] wb_int_o,
    output logic [VW-1:0]        wb_vec_o,
    output logic [REGI_BITS-1:0] wb_dst_o,
    output logic                 err_o,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LINE_W-1:0]    line_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic                 store_q;
    logic [VW-1:0]        data_q;
    logic [VW-1:0]        vec_q;
    logic [VW-1:0]        buf_q;
    logic [VW-1:0]        buf_d;
    logic [REGI_SIZE-1:0] int_q;
    logic [REGI_BITS-1:0] dst_q;
    logic                 ex_fire;
    logic                 is_mem;
    logic                 beat_ack;
    logic                 last_ack;

    // Memory port handshake: a beat transfers on every cycle with mem_req_o && mem_ack_i.
    // While mem_req_o is high without ack, mem_addr_o/mem_we_o/mem_wdata_o are held;
    // mem_ack_i with mem_req_o low is ignored.
    assign ex_fire  = (state_q == IDLE) && ex_valid_i;
    assign is_mem   = mem_read_i || mem_write_i;
    assign beat_ack = (state_q == ACCESS) && mem_ack_i;
    assign last_ack = beat_ack && (beat_q == BEAT_BITS'(BEATS - 1));

    assign stall_o     = (state_q != IDLE);
    assign mem_req_o   = (state_q == ACCESS);
    assign mem_we_o    = (state_q == ACCESS) && store_q;
    assign mem_addr_o  = {line_q, beat_q};
    assign mem_wdata_o = data_q[beat_q*BEAT_W +: BEAT_W];
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_valid_i && is_mem) state_d = ACCESS;
            ACCESS:  if (last_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer including the beat arriving this cycle, so the last beat reaches wb_vec_o directly.
    always_comb begin
        buf_d = buf_q;
        if (beat_ack && !store_q) begin
            buf_d[beat_q*BEAT_W +: BEAT_W] = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            line_q     <= '0;
            beat_q     <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            vec_q      <= '0;
            buf_q      <= '0;
            int_q      <= '0;
            dst_q      <= '0;
            wb_valid_o <= 1'b0;
            wb_wen_o   <= 1'b0;
            wb_int_o   <= '0;
            wb_vec_o   <= '0;
            wb_dst_o   <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            if (ex_fire) begin
                line_q  <= ialu_res_i[LINE_W-1:0];
                beat_q  <= '0;
                store_q <= mem_write_i;
                data_q  <= mem_data_i;
                vec_q   <= valu_res_i;
                buf_q   <= '0;
                int_q   <= ialu_res_i;
                dst_q   <= dst_i;
                err_o   <= mem_read_i && mem_write_i;
                if (!is_mem) begin
                    wb_valid_o <= 1'b1;
                    wb_wen_o   <= 1'b1;
                    wb_int_o   <= ialu_res_i;
                    wb_vec_o   <= valu_res_i;
                    wb_dst_o   <= dst_i;
                end
            end
            if (beat_ack) begin
                buf_q  <= buf_d;
                beat_q <= beat_q + 1'b1;
            end
            if (last_ack) begin
                wb_valid_o <= 1'b1;
                wb_wen_o   <= !store_q;
                wb_int_o   <= int_q;
                wb_vec_o   <= store_q ? vec_q : buf_d;
                wb_dst_o   <= dst_q;
            end
        end
    end

endmodule

// File: tb/tb_m_stage_lsu.sv
// Bench for m_stage_lsu: randomized ops against a behavioural memory/write-back model,
// with a responder that acks beats after programmable wait cycles.
module tb_m_stage_lsu;

    localparam int REGI_SIZE = 16;
    localparam int VW        = 64;
    localparam int BEAT_W    = 16;
    localparam int BEATS     = 4;
    localparam int REGI_BITS = 4;
    localparam int AW        = 8;
    localparam int WB_W      = 1 + REGI_SIZE + VW + REGI_BITS;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 ex_valid_i = 1'b0;
    logic [REGI_SIZE-1:0] ialu_res_i = '0;
    logic [VW-1:0]        valu_res_i = '0;
    logic [VW-1:0]        mem_data_i = '0;
    logic                 mem_read_i = 1'b0;
    logic                 mem_write_i = 1'b0;
    logic [REGI_BITS-1:0] dst_i = '0;
    logic                 stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AW-1:0]        mem_addr_o;
    logic [BEAT_W-1:0]    mem_wdata_o;
    logic [BEAT_W-1:0]    mem_rdata_i = '0;
    logic                 mem_ack_i = 1'b0;
    logic                 wb_valid_o;
    logic                 wb_wen_o;
    logic [REGI_SIZE-1:0] wb_int_o;
    logic [VW-1:0]        wb_vec_o;
    logic [REGI_BITS-1:0] wb_dst_o;
    logic                 err_o;
    logic [1:0]           dbg_state_o;

    m_stage_lsu dut (
        .clk_i(clk), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ialu_res_i(ialu_res_i),
        .valu_res_i(valu_res_i), .mem_data_i(mem_data_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .dst_i(dst_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .wb_valid_o(wb_valid_o),
        .wb_wen_o(wb_wen_o), .wb_int_o(wb_int_o), .wb_vec_o(wb_vec_o), .wb_dst_o(wb_dst_o),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: expected write-back results {wen, int, vec, dst} and beats {we, addr, wdata}
    logic [WB_W-1:0] exp_q[$];
    int              exp_cyc_q[$];
    logic [24:0]     beat_exp_q[$];
    logic [15:0]     ref_mem[256];
    logic [15:0]     dev_mem[256];
    bit              mem_out = 1'b0;
    bit              in_reset = 1'b1;
    int              acked = 0;
    int              clr_cyc = -1;
    int              err_cyc = -1;
    int              wait_mode = 0;
    int              wait_cnt = 0;
    int              cur_rand = 0;
    logic [7:0]      log_addr[$];
    logic [15:0]     log_data[$];
    logic            log_we[$];
    int              req_cycles = 0;
    int              err_pulses = 0;
    logic            last_wen;
    logic [15:0]     last_int;
    logic [63:0]     last_vec;
    logic [3:0]      last_dst;
    int              last_wb_cyc = 0;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle compare plus memory responder, run at the falling edge
    task automatic monitor_step();
        logic [WB_W-1:0] e;
        logic [24:0]     b;
        int              ec;
        int              need;
        if (in_reset || !rst_i) begin
            mem_ack_i = 1'b0;
            return;
        end
        check("stall", stall_o, mem_out);
        check("mem_req", mem_req_o, mem_out && (acked < BEATS));
        check("err", err_o, cyc == err_cyc);
        if (err_o) err_pulses++;
        if (wb_valid_o) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 1'b1, 1'b0);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("wb_wen", wb_wen_o, e[WB_W-1]);
                check("wb_int", wb_int_o, e[WB_W-2 -: REGI_SIZE]);
                check("wb_vec", wb_vec_o, e[REGI_BITS +: VW]);
                check("wb_dst", wb_dst_o, e[REGI_BITS-1:0]);
                if (ec >= 0) check("wb_latency", cyc, ec);
            end
            last_wen = wb_wen_o; last_int = wb_int_o; last_vec = wb_vec_o; last_dst = wb_dst_o;
            last_wb_cyc = cyc;
            if (mem_out) begin
                mem_out = 1'b0;
                acked   = 0;
                clr_cyc = cyc;
            end
        end
        if (mem_req_o) begin
            req_cycles++;
            if (beat_exp_q.size() == 0) begin
                check("beat_unexpected", 1'b1, 1'b0);
                mem_ack_i   = 1'b1;
                mem_rdata_i = '0;
            end else begin
                b = beat_exp_q[0];
                check("beat_addr", mem_addr_o, b[23:16]);
                check("beat_we", mem_we_o, b[24]);
                if (b[24]) check("beat_wdata", mem_wdata_o, b[15:0]);
                need = (wait_mode >= 0) ? wait_mode : cur_rand;
                if (wait_cnt >= need) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = dev_mem[mem_addr_o];
                    if (mem_we_o) dev_mem[mem_addr_o] = mem_wdata_o;
                    log_addr.push_back(mem_addr_o);
                    log_data.push_back(mem_wdata_o);
                    log_we.push_back(mem_we_o);
                    void'(beat_exp_q.pop_front());
                    acked++;
                    wait_cnt = 0;
                    cur_rand = $urandom_range(0, 3);
                end else begin
                    mem_ack_i   = 1'b0;
                    mem_rdata_i = 16'($urandom);
                    wait_cnt++;
                end
            end
        end else begin
            mem_ack_i   = ($urandom_range(0, 3) == 0);
            mem_rdata_i = 16'($urandom);
        end
    endtask

    // Driver: waits for the stage to be free, records the expected outcome, presents one op
    task automatic issue(input logic rd, input logic wr, input logic [15:0] ialu,
                         input logic [63:0] valu, input logic [63:0] mdata, input logic [3:0] dst,
                         input bit wait_done, input bit junk, output int t);
        int          guard;
        int          base;
        logic [63:0] ld;
        logic        mem_op;
        logic        wen;
        guard = 0;
        @(negedge clk); #1;
        while ((mem_out || cyc == clr_cyc) && guard < 300) begin
            @(negedge clk); #1;
            guard++;
        end
        if (guard >= 300) check("issue_timeout", 1'b0, 1'b1);
        mem_op = rd | wr;
        base   = (ialu % 64) * BEATS;
        t      = cyc;
        ld     = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        if (mem_op) begin
            for (int i = 0; i < BEATS; i++) begin
                if (wr) begin
                    beat_exp_q.push_back({1'b1, 8'(base + i), mdata[16*i +: 16]});
                    ref_mem[base+i] = mdata[16*i +: 16];
                end else begin
                    beat_exp_q.push_back({1'b0, 8'(base + i), 16'h0000});
                end
            end
        end
        wen = mem_op ? !wr : 1'b1;
        exp_q.push_back({wen, ialu, (mem_op && !wr) ? ld : valu, dst});
        if (!mem_op) exp_cyc_q.push_back(t + 1);
        else if (wait_mode >= 0) exp_cyc_q.push_back(t + 1 + BEATS * (wait_mode + 1));
        else exp_cyc_q.push_back(-1);
        if (rd && wr) err_cyc = t + 1;
        if (mem_op) begin
            mem_out = 1'b1;
            acked   = 0;
        end
        ex_valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        ialu_res_i = ialu; valu_res_i = valu; mem_data_i = mdata; dst_i = dst;
        @(posedge clk); #1;
        ex_valid_i  = 1'b0;
        mem_read_i  = 1'($urandom); mem_write_i = 1'($urandom);
        ialu_res_i  = 16'($urandom); dst_i = 4'($urandom);
        if (mem_op && wait_done) begin
            guard = 0;
            while (guard < 400) begin
                @(negedge clk); #1;
                guard++;
                if (!mem_out) break;
                if (junk) begin
                    ex_valid_i  = 1'($urandom);
                    mem_read_i  = 1'($urandom);
                    mem_write_i = 1'($urandom);
                    ialu_res_i  = 16'($urandom);
                end
            end
            ex_valid_i = 1'b0;
            if (guard >= 400) check("access_timeout", 1'b0, 1'b1);
        end
    endtask

    initial begin
        int          t;
        int          guard;
        int          kind;
        logic [15:0] sd[4];
        logic [63:0] r64;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_wb_valid", wb_valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_wb_vec", wb_vec_o, 64'h0);
        check("rst_addr", mem_addr_o, 8'h00);
        @(posedge clk); #3;
        rst_i = 1'b1; in_reset = 1'b0;

        // Non-memory op
        wait_mode = 0;
        issue(1'b0, 1'b0, 16'h00AB, 64'hDEAD_BEEF_0000_0001, 64'h0, 4'd3, 1'b0, 1'b0, t);
        @(negedge clk); #1;
        check("nonmem_int", last_int, 16'h00AB);
        check("nonmem_dst", last_dst, 4'd3);
        check("nonmem_wen", last_wen, 1'b1);
        check("nonmem_lat", last_wb_cyc - t, 1);

        // Store, line 5, zero-wait memory
        log_addr.delete(); log_data.delete(); log_we.delete();
        sd = '{16'h7788, 16'h5566, 16'h3344, 16'h1122};
        issue(1'b0, 1'b1, 16'h0005, 64'h0123_4567_89AB_CDEF, 64'h1122334455667788, 4'd1, 1'b1, 1'b0, t);
        check("store_beats", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("store_addr", log_addr[i], 8'(20 + i));
                check("store_data", log_data[i], sd[i]);
            end
        end
        check("store_wen", last_wen, 1'b0);
        check("store_lat", last_wb_cyc - t, 5);

        // Load, line 5, two wait cycles per beat
        wait_mode = 2; req_cycles = 0;
        issue(1'b1, 1'b0, 16'h0005, 64'h0, 64'h0, 4'd7, 1'b1, 1'b1, t);
        check("load_vec", last_vec, 64'h1122334455667788);
        check("load_wen", last_wen, 1'b1);
        check("load_req_cycles", req_cycles, 12);
        check("load_lat", last_wb_cyc - t, 13);

        // Address wrap
        wait_mode = 0;
        log_addr.delete(); log_data.delete(); log_we.delete();
        issue(1'b1, 1'b0, 16'h0047, 64'h0, 64'h0, 4'd2, 1'b1, 1'b0, t);
        check("wrap_beats", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) check("wrap_addr", log_addr[i], 8'(28 + i));
        end

        // Both read and write flags
        wait_mode = 1; err_pulses = 0;
        log_addr.delete(); log_data.delete(); log_we.delete();
        issue(1'b1, 1'b1, 16'h0009, 64'h5A5A, 64'hCAFE_F00D_1234_5678, 4'd4, 1'b1, 1'b0, t);
        check("both_err_pulses", err_pulses, 1);
        check("both_wen", last_wen, 1'b0);
        check("both_beats", log_we.size(), 4);
        if (log_we.size() == 4) begin
            for (int i = 0; i < 4; i++) check("both_we", log_we[i], 1'b1);
        end

        // Reset after the first load beat is acked
        wait_mode = 1; wait_cnt = 0;
        issue(1'b1, 1'b0, 16'h0003, 64'h0, 64'h0, 4'd5, 1'b0, 1'b0, t);
        guard = 0;
        while (acked < 1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_mid_ack_seen", acked >= 1, 1'b1);
        in_reset = 1'b1;
        exp_q.delete(); exp_cyc_q.delete(); beat_exp_q.delete();
        mem_out = 1'b0; acked = 0; err_cyc = -1; wait_cnt = 0;
        rst_i = 1'b0;
        #1;
        check("rst_mid_req", mem_req_o, 1'b0);
        check("rst_mid_stall", stall_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid_wb_valid", wb_valid_o, 1'b0);
        end
        @(posedge clk); #3;
        rst_i = 1'b1; in_reset = 1'b0;
        issue(1'b0, 1'b1, 16'h000A, 64'h77, 64'hA1A2_A3A4_A5A6_A7A8, 4'd6, 1'b1, 1'b0, t);
        check("post_rst_store_lat", last_wb_cyc - t, 9);

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            wait_mode = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            r64  = {$urandom, $urandom};
            issue(kind == 9 || (kind >= 4 && kind <= 6), kind >= 7,
                  {10'($urandom), 6'($urandom_range(0, 7))}, {$urandom, $urandom}, r64,
                  4'($urandom), 1'b1, 1'($urandom), t);
        end

        guard = 0;
        while ((mem_out || exp_q.size() != 0) && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        check("drain_wb", exp_q.size(), 0);
        check("drain_beats", beat_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
